// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: state encoding,
// default cycle counts and counter sizing helpers.
package pll_sup_pkg;

   // State encoding; also what state_dbg reports
   typedef enum logic [2:0] {
      ST_POR       = 3'd0,
      ST_PLLRST    = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_STABLE    = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAIL      = 3'd5
   } pll_state_e;

   // Default timing at the 25 MHz reference clock
   localparam int POR_CYCLES_DEF         = 250;   // 10 us
   localparam int PLLRST_CYCLES_DEF      = 25;    // 1 us
   localparam int LOCK_TIMEOUT_DEF       = 2500;  // 100 us
   localparam int LOCK_STABLE_CYCLES_DEF = 1000;  // 40 us
   localparam int MAX_RETRIES_DEF        = 4;

   // Bits needed to count 0..n-1, never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_ff2.sv
// Generic two-flop synchronizer for a single-bit level signal.
// Both stages clear to 0 on the asynchronous reset.
module sync_ff2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // Two back-to-back flops give the first stage a cycle to resolve
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Lock supervisor for the core-clock PLL. Holds the PLL in reset after
// power-on, waits for a stable lock before releasing the system reset,
// and re-resets the PLL on timeout or lock loss with a bounded retry count.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int POR_CYCLES         = POR_CYCLES_DEF,
   parameter int PLLRST_CYCLES      = PLLRST_CYCLES_DEF,
   parameter int LOCK_TIMEOUT       = LOCK_TIMEOUT_DEF,
   parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
   parameter int MAX_RETRIES        = MAX_RETRIES_DEF   // must be >= 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       force_relock,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fail,
   output logic [7:0] relock_count,
   output logic [2:0] state_dbg
);

   localparam int DW = cnt_width(max_int(max_int(POR_CYCLES, PLLRST_CYCLES), LOCK_STABLE_CYCLES));
   localparam int TW = cnt_width(LOCK_TIMEOUT);
   localparam int RW = cnt_width(MAX_RETRIES + 1);

   logic          locked_s;
   pll_state_e    state_q, state_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [7:0]    relock_q, relock_d;
   logic          pll_rst_q, pll_rst_d;
   logic          sys_rst_q, sys_rst_d;
   logic          ready_q, ready_d;
   logic          fail_q, fail_d;
   logic          tmo_hit;
   logic [RW-1:0] retry_inc;
   pll_state_e    tmo_state;

   // LOCK is asynchronous to the reference clock; only locked_s is used below
   sync_ff2 u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (pll_locked),
      .q   (locked_s)
   );

   // Next-state, counter and output decode
   always_comb begin
      state_d   = state_q;
      dwell_d   = dwell_q;
      tmo_d     = tmo_q;
      retry_d   = retry_q;
      relock_d  = relock_q;
      tmo_hit   = (tmo_q == TW'(LOCK_TIMEOUT - 1));
      retry_inc = retry_q + RW'(1);
      tmo_state = (retry_inc == RW'(MAX_RETRIES)) ? ST_FAIL : ST_PLLRST;

      case (state_q)
         ST_POR: begin
            if (dwell_q == DW'(POR_CYCLES - 1)) begin
               state_d = ST_WAIT_LOCK;
               dwell_d = '0;
               tmo_d   = '0;
            end else begin
               dwell_d = dwell_q + DW'(1);
            end
         end
         ST_PLLRST: begin
            if (dwell_q == DW'(PLLRST_CYCLES - 1)) begin
               state_d = ST_WAIT_LOCK;
               dwell_d = '0;
               tmo_d   = '0;
            end else begin
               dwell_d = dwell_q + DW'(1);
            end
         end
         ST_WAIT_LOCK: begin
            if (tmo_hit) begin
               state_d = tmo_state;
               retry_d = retry_inc;
               dwell_d = '0;
            end else begin
               tmo_d = tmo_q + TW'(1);
               if (locked_s) begin
                  state_d = ST_STABLE;
                  dwell_d = '0;
               end
            end
         end
         ST_STABLE: begin
            // Completing the stable window beats a coincident timeout
            if (locked_s && (dwell_q == DW'(LOCK_STABLE_CYCLES - 1))) begin
               state_d = ST_RUN;
               retry_d = '0;
               dwell_d = '0;
            end else if (tmo_hit) begin
               state_d = tmo_state;
               retry_d = retry_inc;
               dwell_d = '0;
            end else begin
               tmo_d = tmo_q + TW'(1);
               if (!locked_s) begin
                  // A glitch restarts the window but is not a retry
                  state_d = ST_WAIT_LOCK;
                  dwell_d = '0;
               end else begin
                  dwell_d = dwell_q + DW'(1);
               end
            end
         end
         ST_RUN: begin
            // Lock loss takes precedence over a coincident relock request
            if (!locked_s) begin
               state_d = ST_PLLRST;
               dwell_d = '0;
               if (relock_q != 8'hFF) begin
                  relock_d = relock_q + 8'd1;
               end
            end else if (force_relock) begin
               state_d = ST_PLLRST;
               dwell_d = '0;
            end
         end
         ST_FAIL: begin
            if (force_relock) begin
               state_d = ST_PLLRST;
               dwell_d = '0;
               retry_d = '0;
            end
         end
         default: begin
            state_d = ST_POR;
            dwell_d = '0;
         end
      endcase

      pll_rst_d = (state_d == ST_POR) || (state_d == ST_PLLRST);
      sys_rst_d = (state_d != ST_RUN);
      ready_d   = (state_d == ST_RUN);
      fail_d    = (state_d == ST_FAIL);
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_POR;
         dwell_q   <= '0;
         tmo_q     <= '0;
         retry_q   <= '0;
         relock_q  <= '0;
         pll_rst_q <= 1'b1;
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         dwell_q   <= dwell_d;
         tmo_q     <= tmo_d;
         retry_q   <= retry_d;
         relock_q  <= relock_d;
         pll_rst_q <= pll_rst_d;
         sys_rst_q <= sys_rst_d;
         ready_q   <= ready_d;
         fail_q    <= fail_d;
      end
   end

   assign pll_rst      = pll_rst_q;
   assign sys_rst      = sys_rst_q;
   assign ready        = ready_q;
   assign fail         = fail_q;
   assign relock_count = relock_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor with a simple PLL model.
// Expectations are queued against absolute cycle numbers and compared
// on the falling edge of the cycle they refer to.
module tb_pll_lock_supervisor;
   import pll_sup_pkg::*;

   localparam int P_POR = 8;
   localparam int P_RST = 4;
   localparam int P_TMO = 20;
   localparam int P_STB = 10;
   localparam int P_MR  = 3;

   localparam int F_PRST = 0;
   localparam int F_SRST = 1;
   localparam int F_RDY  = 2;
   localparam int F_FAIL = 3;
   localparam int F_CNT  = 4;
   localparam int F_ST   = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked;
   logic       force_relock = 1'b0;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fail;
   logic [7:0] relock_count;
   logic [2:0] state_dbg;

   logic lk_model  = 1'b0;
   logic pll_force = 1'b0;
   logic pll_drop  = 1'b0;
   int   pcnt      = 0;
   int   cyc       = 0;
   int   n_chk     = 0;
   int   n_err     = 0;
   int   exp_cnt   = 0;

   typedef struct {
      int    cyc;
      int    fld;
      int    exp;
      string tag;
   } exp_t;
   exp_t sb[$];

   assign pll_locked = (lk_model | pll_force) & ~pll_drop;

   pll_lock_supervisor #(
      .POR_CYCLES         (P_POR),
      .PLLRST_CYCLES      (P_RST),
      .LOCK_TIMEOUT       (P_TMO),
      .LOCK_STABLE_CYCLES (P_STB),
      .MAX_RETRIES        (P_MR)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pll_locked   (pll_locked),
      .force_relock (force_relock),
      .pll_rst      (pll_rst),
      .sys_rst      (sys_rst),
      .ready        (ready),
      .fail         (fail),
      .relock_count (relock_count),
      .state_dbg    (state_dbg)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // PLL model: LOCK drops while RST is high, rises 5 cycles after RST falls
   always @(posedge clk) begin
      #2;
      if (pll_rst) begin
         pcnt     = 0;
         lk_model = 1'b0;
      end else begin
         if (pcnt < 5) pcnt++;
         lk_model = (pcnt >= 5);
      end
   end

   task automatic chk_val(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, act, exp);
      end
   endtask

   function automatic int obs(input int fld);
      case (fld)
         F_PRST:  return int'(pll_rst);
         F_SRST:  return int'(sys_rst);
         F_RDY:   return int'(ready);
         F_FAIL:  return int'(fail);
         F_CNT:   return int'(relock_count);
         default: return int'(state_dbg);
      endcase
   endfunction

   task automatic expect_at(input int k, input int fld, input int exp, input string tag);
      exp_t e;
      e.cyc = cyc + k;
      e.fld = fld;
      e.exp = exp;
      e.tag = tag;
      sb.push_back(e);
   endtask

   // Scoreboard: pop every expectation that falls due in this cycle
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            chk_val(sb[i].tag, obs(sb[i].fld), sb[i].exp);
            sb.delete(i);
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: cycle %0d reached, limit 40000", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, r;

      // Reset values while rst is held
      cycles(2);
      expect_at(1, F_PRST, 1, "rst_pll_rst");
      expect_at(1, F_SRST, 1, "rst_sys_rst");
      expect_at(1, F_RDY,  0, "rst_ready");
      expect_at(1, F_FAIL, 0, "rst_fail");
      expect_at(1, F_CNT,  0, "rst_relock");
      expect_at(1, F_ST,   int'(ST_POR), "rst_state");
      cycles(1);

      // Clean lock: POR 8 cycles, lock 5 cycles after pll_rst falls
      rst = 1'b0;
      n = cyc;
      for (int k = 1; k < P_POR; k++) expect_at(k, F_PRST, 1, "por_pll_rst_hi");
      expect_at(P_POR, F_PRST, 0, "por_pll_rst_lo");
      expect_at(P_POR, F_ST, int'(ST_WAIT_LOCK), "por_to_wait");
      // first edge sampling lock = n+13, release 12 edges later
      expect_at(24, F_RDY,  0, "clean_ready_early");
      expect_at(25, F_RDY,  1, "clean_ready");
      expect_at(25, F_SRST, 0, "clean_sys_rst");
      expect_at(25, F_ST,   int'(ST_RUN), "clean_state");
      expect_at(25, F_CNT,  0, "clean_relock");
      wait_to(n + 27);

      // force_relock in RUN: PLL re-reset, no count change
      r = cyc;
      force_relock = 1'b1;
      expect_at(1, F_ST,   int'(ST_PLLRST), "force_state");
      expect_at(1, F_PRST, 1, "force_pll_rst");
      expect_at(1, F_CNT,  0, "force_relock_cnt");
      expect_at(4, F_PRST, 1, "force_pll_rst_end");
      expect_at(5, F_PRST, 0, "force_pll_rst_lo");
      expect_at(21, F_RDY, 0, "force_ready_early");
      expect_at(22, F_RDY, 1, "force_ready");
      expect_at(22, F_CNT, 0, "force_relock_cnt2");
      cycles(1);
      force_relock = 1'b0;
      wait_to(r + 22);

      // Lock loss coinciding with force_relock counts as a loss
      r = cyc;
      pll_drop = 1'b1;
      exp_cnt  = 1;
      expect_at(2, F_RDY,  1, "both_ready_hold");
      expect_at(3, F_ST,   int'(ST_PLLRST), "both_state");
      expect_at(3, F_CNT,  exp_cnt, "both_relock");
      expect_at(3, F_SRST, 1, "both_sys_rst");
      expect_at(24, F_ST,  int'(ST_RUN), "both_rerun");
      wait_to(r + 2);
      force_relock = 1'b1;
      wait_to(r + 3);
      force_relock = 1'b0;
      wait_to(r + 4);
      pll_drop = 1'b0;
      wait_to(r + 24);

      // Repeated lock loss in RUN; relock_count saturates at 255
      for (int i = 0; i < 300; i++) begin
         r = cyc;
         pll_drop = 1'b1;
         exp_cnt  = (exp_cnt < 255) ? exp_cnt + 1 : 255;
         expect_at(2, F_RDY,  1, "loss_ready_hold");
         expect_at(3, F_SRST, 1, "loss_sys_rst");
         expect_at(3, F_PRST, 1, "loss_pll_rst");
         expect_at(3, F_ST,   int'(ST_PLLRST), "loss_state");
         expect_at(3, F_CNT,  exp_cnt, "loss_relock");
         expect_at(6, F_PRST, 1, "loss_pll_rst_end");
         expect_at(7, F_PRST, 0, "loss_pll_rst_lo");
         expect_at(23, F_RDY, 0, "loss_ready_early");
         expect_at(24, F_RDY, 1, "loss_ready");
         wait_to(r + 4);
         pll_drop = 1'b0;
         wait_to(r + 24);
      end

      // Lock glitch in STABLE: back to WAIT_LOCK, full window again
      pll_force = 1'b1;
      do_reset();
      n = cyc;
      expect_at(9,  F_ST, int'(ST_STABLE), "glitch_stable");
      expect_at(12, F_ST, int'(ST_STABLE), "glitch_force_ignored");
      expect_at(15, F_ST, int'(ST_STABLE), "glitch_stable_c6");
      expect_at(16, F_ST, int'(ST_WAIT_LOCK), "glitch_back");
      expect_at(17, F_ST, int'(ST_STABLE), "glitch_restable");
      expect_at(26, F_RDY, 0, "glitch_ready_early");
      expect_at(27, F_RDY, 1, "glitch_ready");
      for (int k = P_POR; k <= 27; k++) expect_at(k, F_PRST, 0, "glitch_no_pll_rst");
      wait_to(n + 11);
      force_relock = 1'b1;
      wait_to(n + 12);
      force_relock = 1'b0;
      wait_to(n + 13);
      pll_drop = 1'b1;
      wait_to(n + 14);
      pll_drop = 1'b0;
      wait_to(n + 27);
      pll_force = 1'b0;

      // Timeouts with no lock: 3 timeouts, 2 pll_rst pulses, then FAIL
      pll_drop = 1'b1;
      do_reset();
      n = cyc;
      expect_at(4,  F_ST, int'(ST_POR), "tmo_force_in_por");
      expect_at(8,  F_ST, int'(ST_WAIT_LOCK), "tmo_wait1");
      expect_at(27, F_ST, int'(ST_WAIT_LOCK), "tmo_wait1_end");
      expect_at(28, F_ST, int'(ST_PLLRST), "tmo_retry1");
      for (int k = 28; k < 32; k++) expect_at(k, F_PRST, 1, "tmo_pulse1");
      expect_at(32, F_PRST, 0, "tmo_pulse1_lo");
      expect_at(32, F_ST, int'(ST_WAIT_LOCK), "tmo_wait2");
      expect_at(41, F_ST, int'(ST_WAIT_LOCK), "tmo_force_in_wait");
      expect_at(51, F_ST, int'(ST_WAIT_LOCK), "tmo_wait2_end");
      expect_at(52, F_ST, int'(ST_PLLRST), "tmo_retry2");
      for (int k = 52; k < 56; k++) expect_at(k, F_PRST, 1, "tmo_pulse2");
      expect_at(56, F_ST, int'(ST_WAIT_LOCK), "tmo_wait3");
      expect_at(75, F_ST, int'(ST_WAIT_LOCK), "tmo_wait3_end");
      expect_at(76, F_ST,   int'(ST_FAIL), "tmo_fail_state");
      expect_at(76, F_FAIL, 1, "tmo_fail");
      expect_at(76, F_PRST, 0, "tmo_fail_pll_rst");
      expect_at(76, F_SRST, 1, "tmo_fail_sys_rst");
      expect_at(76, F_RDY,  0, "tmo_fail_ready");
      for (int k = 77; k <= 176; k++) expect_at(k, F_ST, int'(ST_FAIL), "tmo_fail_sticky");
      wait_to(n + 3);
      force_relock = 1'b1;
      wait_to(n + 4);
      force_relock = 1'b0;
      wait_to(n + 40);
      force_relock = 1'b1;
      wait_to(n + 41);
      force_relock = 1'b0;
      wait_to(n + 176);

      // FAIL recovery: retries cleared, three fresh timeouts before FAIL
      r = cyc;
      force_relock = 1'b1;
      expect_at(1,  F_ST,   int'(ST_PLLRST), "rec_pllrst");
      expect_at(1,  F_FAIL, 0, "rec_fail_clr");
      expect_at(1,  F_PRST, 1, "rec_pll_rst");
      expect_at(5,  F_ST, int'(ST_WAIT_LOCK), "rec_wait1");
      expect_at(25, F_ST, int'(ST_PLLRST), "rec_retry1");
      expect_at(29, F_ST, int'(ST_WAIT_LOCK), "rec_wait2");
      expect_at(49, F_ST, int'(ST_PLLRST), "rec_retry2");
      expect_at(53, F_ST, int'(ST_WAIT_LOCK), "rec_wait3");
      expect_at(72, F_ST, int'(ST_WAIT_LOCK), "rec_wait3_end");
      expect_at(73, F_ST, int'(ST_FAIL), "rec_fail_again");
      expect_at(73, F_FAIL, 1, "rec_fail_flag");
      cycles(1);
      force_relock = 1'b0;
      wait_to(r + 80);
      pll_drop = 1'b0;

      // Asynchronous reset in the middle of STABLE
      pll_force = 1'b1;
      do_reset();
      n = cyc;
      expect_at(12, F_ST, int'(ST_STABLE), "arst_in_stable");
      wait_to(n + 12);
      #1;
      rst = 1'b1;
      #1;
      chk_val("arst_pll_rst", int'(pll_rst), 1);
      chk_val("arst_sys_rst", int'(sys_rst), 1);
      chk_val("arst_ready",   int'(ready), 0);
      chk_val("arst_fail",    int'(fail), 0);
      chk_val("arst_relock",  int'(relock_count), 0);
      chk_val("arst_state",   int'(state_dbg), int'(ST_POR));
      cycles(2);
      rst = 1'b0;
      pll_force = 1'b0;
      cycles(2);

      chk_val("sb_pending", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
